// File: rtl/pme_pkg.sv
// Shared constants for the PME event controller: edge-mode encodings and
// the parameter limits the controller is built for.
package pme_pkg;

  localparam logic PME_EDGE_ASSERT = 1'b0;
  localparam logic PME_EDGE_BOTH   = 1'b1;

  localparam int unsigned PME_CH_MAX = 32;
  localparam int unsigned PME_DB_MAX = 8;

endpackage

// File: rtl/pme_event_ctrl_if.sv
// Bundle between wake-source/register side and the PME event controller.
// master drives sources and register strobes; slave is the controller.
interface pme_event_ctrl_if #(
  parameter int unsigned CH_NUM = 8
);

  logic              t1hz_tick;
  logic [CH_NUM-1:0] pme_src;
  logic [CH_NUM-1:0] pme_mask_n;
  logic [CH_NUM-1:0] edge_mode;
  logic [CH_NUM-1:0] sts_clr;
  logic [CH_NUM-1:0] db_pme_src;
  logic [CH_NUM-1:0] pme_sts;
  logic              pme_event_pls;
  logic              pme_irq;

  modport master (
    output t1hz_tick, pme_src, pme_mask_n, edge_mode, sts_clr,
    input  db_pme_src, pme_sts, pme_event_pls, pme_irq
  );

  modport slave (
    input  t1hz_tick, pme_src, pme_mask_n, edge_mode, sts_clr,
    output db_pme_src, pme_sts, pme_event_pls, pme_irq
  );

endinterface

// File: rtl/pme_db_chan.sv
// One PME channel: tick-sampled history, hysteresis debounce and
// rise/fall detection against a one-clock delayed copy of the debounced state.
module pme_db_chan #(
  parameter int unsigned DB_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic src_i,
  output logic db_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [DB_DEPTH-1:0] hist_q, hist_d;
  logic                db_q, db_d;
  logic                db_dly_q;

  // Output only moves on a unanimous history, so a lone glitch sample holds it.
  always_comb begin
    hist_d = hist_q;
    db_d   = db_q;
    if (tick_i) begin
      hist_d = (hist_q << 1) | DB_DEPTH'(src_i);
    end
    if (&hist_q) begin
      db_d = 1'b1;
    end else if (~|hist_q) begin
      db_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  assign db_o     = db_q;
  assign rise_c_o = db_q & ~db_dly_q;
  assign fall_c_o = ~db_q & db_dly_q;

endmodule

// File: rtl/pme_event_ctrl.sv
// Multi-channel PME debouncer with sticky W1C status, one aggregated event
// pulse and a masked level interrupt toward the register block.
module pme_event_ctrl
  import pme_pkg::*;
#(
  parameter int unsigned CH_NUM   = 8,
  parameter int unsigned DB_DEPTH = 2
) (
  input  logic             clk,
  input  logic             pgoodaux,
  pme_event_ctrl_if.slave  bus
);

  if ((CH_NUM == 0) || (CH_NUM > PME_CH_MAX) ||
      (DB_DEPTH == 0) || (DB_DEPTH > PME_DB_MAX)) begin : g_bad_param
    $error("pme_event_ctrl: CH_NUM or DB_DEPTH out of range");
  end

  logic [CH_NUM-1:0] db;
  logic [CH_NUM-1:0] rise_c;
  logic [CH_NUM-1:0] fall_c;
  logic [CH_NUM-1:0] qual_c;
  logic [CH_NUM-1:0] sts_q, sts_d;
  logic              pls_q, pls_d;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    pme_db_chan #(
      .DB_DEPTH (DB_DEPTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (pgoodaux),
      .tick_i   (bus.t1hz_tick),
      .src_i    (bus.pme_src[i]),
      .db_o     (db[i]),
      .rise_c_o (rise_c[i]),
      .fall_c_o (fall_c[i])
    );
  end

  // Set beats clear; masking blocks new events but never drops pending status.
  always_comb begin
    qual_c = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      qual_c[i] = (rise_c[i] | (fall_c[i] & (bus.edge_mode[i] == PME_EDGE_BOTH)))
                  & bus.pme_mask_n[i];
    end
    sts_d = (sts_q & ~bus.sts_clr) | qual_c;
    pls_d = |qual_c;
  end

  always_ff @(posedge clk or negedge pgoodaux) begin
    if (!pgoodaux) begin
      sts_q <= '0;
      pls_q <= 1'b0;
    end else begin
      sts_q <= sts_d;
      pls_q <= pls_d;
    end
  end

  assign bus.db_pme_src    = db;
  assign bus.pme_sts       = sts_q;
  assign bus.pme_event_pls = pls_q;
  assign bus.pme_irq       = |(sts_q & bus.pme_mask_n);

endmodule

// File: tb/tb_pme_event_ctrl.sv
// Directed bench for pme_event_ctrl (8 channels, depth 2): expected pulses and
// level snapshots are queued by the stimulus and checked by a monitor process.
module tb_pme_event_ctrl;

  localparam int unsigned CH = 8;

  logic        clk = 1'b0;
  logic        pgoodaux = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pme_event_ctrl_if #(.CH_NUM(CH)) bus ();

  pme_event_ctrl #(
    .CH_NUM   (CH),
    .DB_DEPTH (2)
  ) dut (
    .clk      (clk),
    .pgoodaux (pgoodaux),
    .bus      (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  sts;
  } pls_exp_t;

  typedef struct {
    string      name;
    logic [7:0] db;
    logic [7:0] sts;
    logic       irq;
  } snap_t;

  pls_exp_t pls_q[$];
  snap_t    snap_q[$];
  int       vectors = 0;
  int       miscompares = 0;

  // Monitor: samples 2 time units after each falling edge.
  initial begin
    snap_t    s;
    pls_exp_t p;
    forever begin
      @(negedge clk);
      #2;
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        vectors++;
        if (bus.db_pme_src !== s.db || bus.pme_sts !== s.sts || bus.pme_irq !== s.irq) begin
          miscompares++;
          $display("FAIL %s @cyc %0d: got db=%h sts=%h irq=%b, want db=%h sts=%h irq=%b",
                   s.name, cyc, bus.db_pme_src, bus.pme_sts, bus.pme_irq, s.db, s.sts, s.irq);
        end
      end
      while (pls_q.size() > 0 && pls_q[0].cyc < cyc) begin
        p = pls_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing: got no pulse at cyc %0d, want pulse with sts=%h", p.cyc, p.sts);
      end
      if (bus.pme_event_pls === 1'b1) begin
        vectors++;
        if (pls_q.size() > 0 && pls_q[0].cyc == cyc) begin
          p = pls_q.pop_front();
          if (bus.pme_sts !== p.sts) begin
            miscompares++;
            $display("FAIL pulse_sts @cyc %0d: got sts=%h, want sts=%h", cyc, bus.pme_sts, p.sts);
          end
        end else begin
          miscompares++;
          $display("FAIL unexpected_pulse @cyc %0d: got pls=1, want pls=0", cyc);
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sample strobe; e is the clock edge that samples v.
  task automatic tick(input logic [7:0] v, output int unsigned e);
    @(negedge clk);
    bus.pme_src   = v;
    bus.t1hz_tick = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.t1hz_tick = 1'b0;
  endtask

  task automatic two_ticks(input logic [7:0] v, output int unsigned e);
    int unsigned e0;
    tick(v, e0);
    cyc_wait(2);
    tick(v, e);
  endtask

  task automatic snap(input string n, input logic [7:0] db, input logic [7:0] sts, input logic irq);
    snap_q.push_back('{name: n, db: db, sts: sts, irq: irq});
  endtask

  task automatic exp_pulse(input int unsigned c, input logic [7:0] sts);
    pls_q.push_back('{cyc: c, sts: sts});
  endtask

  initial begin
    int unsigned e;
    bus.t1hz_tick  = 1'b0;
    bus.pme_src    = '0;
    bus.pme_mask_n = 8'hFF;
    bus.edge_mode  = 8'h00;
    bus.sts_clr    = '0;

    cyc_wait(3);
    snap("reset", 8'h00, 8'h00, 1'b0);
    cyc_wait(1);
    pgoodaux = 1'b1;
    cyc_wait(2);

    // ch3 rise: db at E+1, status and pulse after E+2
    two_ticks(8'h08, e);
    exp_pulse(e + 2, 8'h08);
    snap("t1_hist_full", 8'h00, 8'h00, 1'b0);
    cyc_wait(1);
    snap("t1_db_rise", 8'h08, 8'h00, 1'b0);
    cyc_wait(1);
    snap("t1_sts_set", 8'h08, 8'h08, 1'b1);
    cyc_wait(3);

    // ch0 alternating samples never settle
    tick(8'h09, e); cyc_wait(2);
    tick(8'h08, e); cyc_wait(2);
    tick(8'h09, e); cyc_wait(2);
    tick(8'h08, e); cyc_wait(3);
    snap("t2_glitch", 8'h08, 8'h08, 1'b1);

    // ch1 both edges, ch2 assert only; simultaneous rises give one pulse
    bus.edge_mode = 8'h02;
    two_ticks(8'h0E, e);
    exp_pulse(e + 2, 8'h0E);
    cyc_wait(2);
    snap("t3_rise_12", 8'h0E, 8'h0E, 1'b1);
    cyc_wait(2);
    two_ticks(8'h0C, e);
    exp_pulse(e + 2, 8'h0E);
    cyc_wait(2);
    snap("t3_ch1_fall", 8'h0C, 8'h0E, 1'b1);
    cyc_wait(2);
    two_ticks(8'h08, e);
    cyc_wait(2);
    snap("t3_ch2_fall_quiet", 8'h08, 8'h0E, 1'b1);
    cyc_wait(3);

    @(negedge clk);
    bus.sts_clr = 8'hFF;
    cyc_wait(1);
    bus.sts_clr = 8'h00;
    snap("clr_all", 8'h08, 8'h00, 1'b0);

    // masked ch5 debounces but raises nothing, even once unmasked
    bus.pme_mask_n = 8'hDF;
    two_ticks(8'h28, e);
    cyc_wait(2);
    snap("t4_masked", 8'h28, 8'h00, 1'b0);
    cyc_wait(2);
    bus.pme_mask_n = 8'hFF;
    snap("t4_unmask", 8'h28, 8'h00, 1'b0);
    cyc_wait(2);

    // ch3 re-rise with a clear strobe in the same cycle; clear alone after
    two_ticks(8'h20, e);
    cyc_wait(3);
    snap("t5_ch3_low", 8'h20, 8'h00, 1'b0);
    two_ticks(8'h28, e);
    exp_pulse(e + 2, 8'h08);
    cyc_wait(1);
    bus.sts_clr = 8'h08;
    cyc_wait(1);
    snap("t5_set_wins", 8'h28, 8'h08, 1'b1);
    cyc_wait(1);
    bus.sts_clr = 8'h00;
    snap("t5_clr_alone", 8'h28, 8'h00, 1'b0);
    cyc_wait(2);

    // reset after one of two ticks, then fresh debounce from empty history
    tick(8'h68, e);
    cyc_wait(1);
    pgoodaux = 1'b0;
    snap("t6_reset_async", 8'h00, 8'h00, 1'b0);
    cyc_wait(2);
    pgoodaux = 1'b1;
    cyc_wait(2);
    tick(8'h68, e);
    cyc_wait(3);
    snap("t6_one_fresh_tick", 8'h00, 8'h00, 1'b0);
    tick(8'h68, e);
    exp_pulse(e + 2, 8'h68);
    cyc_wait(1);
    snap("t6_db_after_two", 8'h68, 8'h00, 1'b0);
    cyc_wait(1);
    snap("t6_rise_after_reset", 8'h68, 8'h68, 1'b1);
    cyc_wait(5);

    while (pls_q.size() > 0) begin
      pls_exp_t p;
      p = pls_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL pulse_never_seen: got nothing, want pulse at cyc %0d sts=%h", p.cyc, p.sts);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pme_event_ctrl.md
# pme_event_ctrl

Multi-channel successor to the single-input PME debouncer. It debounces `CH_NUM` independent PME/wake sources on a slow sample tick, with per-channel hysteresis. It detects qualified edges per channel and keeps sticky per-channel status with write-1-to-clear. It drives one aggregated 1-clock event pulse plus a level interrupt to the XREG block, and sits in the aux-power domain between the board wake sources and the register/interrupt logic.

## Interface
Parameters:
- `CH_NUM`, 8: number of PME source channels; legal range 1..32.
- `DB_DEPTH`, 2: consecutive tick samples needed to change a debounced state; legal range 1..8.

Ports:
- `clk`  in  1  aux-domain clock.
- `pgoodaux`  in  1  reset; asynchronous assert, active-low.
- `t1hz_tick`  in  1  one-clock sample strobe.
- `pme_src`  in  CH_NUM  raw PME sources, active-high, already synchronised.
- `pme_mask_n`  in  CH_NUM  per-channel enable; 0 = channel cannot set status, pulse or interrupt.
- `edge_mode`  in  CH_NUM  0 = assert edge only; 1 = assert and deassert edges.
- `sts_clr`  in  CH_NUM  one-clock write-1-to-clear strobes for `pme_sts`.
- `db_pme_src`  out  CH_NUM  debounced source state.
- `pme_sts`  out  CH_NUM  sticky per-channel event status.
- `pme_event_pls`  out  1  one-clock pulse to XREG on any new qualified event.
- `pme_irq`  out  1  level: OR of `pme_sts & pme_mask_n`.

## Operation
- Sampling: on each clock where `t1hz_tick`=1, each channel shifts `pme_src[i]` into a `DB_DEPTH`-bit history register.
- Debounce with hysteresis:
  - `db_pme_src[i]` sets when the history is all ones.
  - It clears when the history is all zeros.
  - Otherwise it holds.
  - A single glitch sample therefore never toggles the output.
- Edge detect: `db_pme_src` is delayed by one register.
  - Rise = db & ~db_d.
  - Fall = ~db & db_d.
  - Qualified edge = (rise | (fall & edge_mode)) & pme_mask_n.
- Status: a qualified edge sets `pme_sts[i]`; `sts_clr[i]` clears it.
  - If set and clear occur in the same cycle, set wins.
  - Masking does not clear existing status.
- Pulse: `pme_event_pls` is registered, high for one clock when any channel has a qualified edge that cycle.
  - Simultaneous edges on several channels produce one pulse.
  - Edges in consecutive cycles produce consecutive pulses.
- Interrupt: `pme_irq` is combinational from the registered `pme_sts` and `pme_mask_n`.
  - Unmasking a channel with pending status raises `pme_irq` without a pulse.
- `edge_mode` and `pme_mask_n` are sampled at use; changing them mid-debounce does not affect the history.

## Timing
- Reset (`pgoodaux`=0) forces, asynchronously:
  - history registers to 0;
  - `db_pme_src`, its delay register, `pme_sts` and `pme_event_pls` to 0;
  - `pme_irq` to 0 as a consequence.
- A source held high at reset release is reported as a rising event once debounced.
- Let edge E be the clock of the `DB_DEPTH`-th consecutive tick sampling 1.
  - History is full after E.
  - `db_pme_src` rises at E+1.
  - `pme_sts` sets and `pme_event_pls` is high for the cycle after E+2.
- Deassert latency is identical and symmetric.
- Reset asserted mid-debounce discards the partial history; no pulse is produced on release.
- `DB_DEPTH`=1: the debounced output follows each tick sample.

## Structure
- Shared package `pme_pkg`:
  - `PME_EDGE_ASSERT`=1'b0 and `PME_EDGE_BOTH`=1'b1 constants;
  - max limits `PME_CH_MAX`=32 and `PME_DB_MAX`=8.
- Sub-module `pme_db_chan`, instantiated `CH_NUM` times via generate:
  - contains history, hysteresis debounce, delay register and rise/fall outputs.
- Top level holds status, pulse aggregation and interrupt OR.

## Test plan
- CH_NUM=8, DB_DEPTH=2; `pme_src[3]`=1 for 2 ticks, mask all 1 -> `db_pme_src[3]`=1 at E+1; `pme_sts`=8'h08 and a single 1-clock `pme_event_pls` after E+2; `pme_irq`=1.
- Pattern 1,0,1,0 across ticks on ch0 -> `db_pme_src[0]` stays 0; no pulse; `pme_sts`=0.
- ch1 `edge_mode`=1: assert then deassert, each held 2 ticks -> two pulses. ch2 `edge_mode`=0, same stimulus -> one pulse.
- ch5 masked (`pme_mask_n[5]`=0) and asserted -> `db_pme_src[5]`=1, no status, no pulse. Later unmask with status still 0 -> `pme_irq`=0.
- `sts_clr[3]` in the same cycle as a new ch3 qualified edge -> `pme_sts[3]` remains 1. `sts_clr[3]` alone next cycle -> `pme_sts[3]`=0 and `pme_irq`=0.
- Drop `pgoodaux` after one of two required ticks, then release -> all outputs 0 immediately; the next valid event needs 2 fresh ticks.
